// File: rtl/par_chk_serial.sv
// Serial parity checker for the UART RX path: assembles the data word LSB
// first, accumulates parity per bit, checks the parity bit on strobe and
// keeps per-frame, sticky and counted error status.
module par_chk_serial #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  data_bit_valid,
  input  logic                  par_chk_en,
  input  logic                  sampled_bit,
  input  logic [1:0]            par_mode,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  chk_done,
  output logic                  par_err,
  output logic                  len_err,
  output logic                  par_err_sticky,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  // Bit counter must reach DATA_WIDTH+1 to flag an overlength frame.
  localparam int BCW = $clog2(DATA_WIDTH + 2);
  localparam logic [BCW-1:0] FULL = BCW'(DATA_WIDTH);
  localparam logic [BCW-1:0] OVER = BCW'(DATA_WIDTH + 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t         state, state_nxt;
  logic           acc;
  logic [BCW-1:0] bit_cnt;
  logic           do_start, do_chk, do_bit;
  logic           exp_par, perr_now;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Input priority decode, expected parity and next state.
  always_comb begin
    state_nxt = state;
    do_start  = frame_start;
    do_chk    = !frame_start && (state == COLLECT) && par_chk_en;
    do_bit    = !frame_start && !par_chk_en && (state == COLLECT) && data_bit_valid;
    unique case (par_mode)
      2'b00:   exp_par = acc;
      2'b01:   exp_par = ~acc;
      2'b10:   exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
    perr_now = (sampled_bit != exp_par);
    if (do_start)    state_nxt = COLLECT;
    else if (do_chk) state_nxt = IDLE;
  end

  // Word assembly, parity accumulation and bit counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      acc      <= 1'b0;
      bit_cnt  <= '0;
    end else if (do_start) begin
      // A bit arriving with the start strobe becomes bit 0 of the new frame.
      data_out    <= '0;
      data_out[0] <= data_bit_valid & sampled_bit;
      acc         <= data_bit_valid & sampled_bit;
      bit_cnt     <= data_bit_valid ? BCW'(1) : '0;
    end else if (do_bit) begin
      if (bit_cnt < FULL) begin
        for (int i = 0; i < DATA_WIDTH; i++)
          if (bit_cnt == BCW'(i)) data_out[i] <= sampled_bit;
        acc     <= acc ^ sampled_bit;
        bit_cnt <= bit_cnt + 1'b1;
      end else begin
        bit_cnt <= OVER;
      end
    end
  end

  // Per-frame check result and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_done <= 1'b0;
      par_err  <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      chk_done <= do_chk;
      if (do_chk) begin
        par_err <= perr_now;
        len_err <= (bit_cnt != FULL);
      end
    end
  end

  // Sticky flag and saturating counter; a new error outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_sticky <= 1'b0;
      err_cnt        <= '0;
    end else if (do_chk && perr_now) begin
      par_err_sticky <= 1'b1;
      if (err_clr)              err_cnt <= CNT_WIDTH'(1);
      else if (err_cnt != '1)   err_cnt <= err_cnt + 1'b1;
    end else if (err_clr) begin
      par_err_sticky <= 1'b0;
      err_cnt        <= '0;
    end
  end

endmodule

// File: tb/tb_par_chk_serial.sv
// Scoreboard bench for par_chk_serial: two instances share stimulus, one with
// the default 8-bit counter and one with a 2-bit counter for saturation.
module tb_par_chk_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0, data_bit_valid = 1'b0, par_chk_en = 1'b0;
  logic       sampled_bit = 1'b0, err_clr = 1'b0;
  logic [1:0] par_mode = 2'b00;

  logic [7:0] data_out, data_out2;
  logic       chk_done, par_err, len_err, sticky;
  logic       chk_done2, par_err2, len_err2, sticky2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct { logic [7:0] data; logic perr; logic lerr; } exp_t;
  exp_t q[$];

  logic       m_sticky = 1'b0;
  logic [7:0] m_cnt = '0;
  logic [1:0] m_cnt2 = '0;

  par_chk_serial #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .data_bit_valid(data_bit_valid),
    .par_chk_en(par_chk_en), .sampled_bit(sampled_bit), .par_mode(par_mode), .err_clr(err_clr),
    .data_out(data_out), .chk_done(chk_done), .par_err(par_err), .len_err(len_err),
    .par_err_sticky(sticky), .err_cnt(err_cnt));

  par_chk_serial #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .data_bit_valid(data_bit_valid),
    .par_chk_en(par_chk_en), .sampled_bit(sampled_bit), .par_mode(par_mode), .err_clr(err_clr),
    .data_out(data_out2), .chk_done(chk_done2), .par_err(par_err2), .len_err(len_err2),
    .par_err_sticky(sticky2), .err_cnt(err_cnt2));

  always #5 clk = ~clk;

  // Scoreboard: every chk_done pops one expected result.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (chk_done2 !== chk_done) begin
        errors++;
        $display("FAIL done_match: dut=%b dut2=%b", chk_done, chk_done2);
      end
      if (chk_done === 1'b1) begin
        done_cnt++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stray_chk_done: got chk_done=1, required no pending check");
        end else begin
          exp_t e;
          e = q.pop_front();
          if ({data_out, par_err, len_err} !== {e.data, e.perr, e.lerr} ||
              {data_out2, par_err2, len_err2} !== {e.data, e.perr, e.lerr}) begin
            errors++;
            $display("FAIL result: data=%h/%h perr=%b/%b lerr=%b/%b required data=%h perr=%b lerr=%b",
                     data_out, data_out2, par_err, par_err2, len_err, len_err2, e.data, e.perr, e.lerr);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  // One frame: start, nbits data bits, parity strobe; model expectations.
  task automatic send_frame(input logic [8:0] data, input int nbits, input logic par,
                            input logic [1:0] mode, input bit fs_bit, input bit clr, input string name);
    int d0;
    logic [7:0] dm;
    logic x, e, perr;
    exp_t ex;
    d0 = done_cnt; dm = '0; x = 1'b0;
    for (int i = 0; i < nbits && i < 8; i++) begin dm[i] = data[i]; x ^= data[i]; end
    case (mode)
      2'b00: e = x;
      2'b01: e = ~x;
      2'b10: e = 1'b1;
      default: e = 1'b0;
    endcase
    perr = (par != e);
    @(posedge clk); #1;
    frame_start = 1'b1; par_mode = mode ^ 2'b01;
    if (fs_bit) begin data_bit_valid = 1'b1; sampled_bit = data[0]; end
    for (int i = (fs_bit ? 1 : 0); i < nbits; i++) begin
      @(posedge clk); #1;
      frame_start = 1'b0; data_bit_valid = 1'b1; sampled_bit = data[i];
    end
    @(posedge clk); #1;
    frame_start = 1'b0; data_bit_valid = 1'b0; par_chk_en = 1'b1;
    sampled_bit = par; par_mode = mode; err_clr = clr;
    ex.data = dm; ex.perr = perr; ex.lerr = (nbits != 8);
    q.push_back(ex);
    if (perr) begin
      m_sticky = 1'b1;
      m_cnt  = clr ? 8'd1 : ((m_cnt == 8'hFF) ? m_cnt : m_cnt + 8'd1);
      m_cnt2 = clr ? 2'd1 : ((m_cnt2 == 2'd3) ? m_cnt2 : m_cnt2 + 2'd1);
    end else if (clr) begin
      m_sticky = 1'b0; m_cnt = '0; m_cnt2 = '0;
    end
    @(posedge clk); #1;
    par_chk_en = 1'b0; err_clr = 1'b0; par_mode = 2'b11;
    @(posedge clk); #1;
    checks++;
    if (done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d pulses, required 1", name, done_cnt - d0);
    end
    checks++;
    if ({sticky, sticky2, err_cnt, err_cnt2} !== {m_sticky, m_sticky, m_cnt, m_cnt2}) begin
      errors++;
      $display("FAIL %s_status: sticky=%b/%b cnt=%0d/%0d required sticky=%b cnt=%0d/%0d",
               name, sticky, sticky2, err_cnt, err_cnt2, m_sticky, m_cnt, m_cnt2);
    end
    checks++;
    if ({data_out, par_err, len_err, chk_done} !== {dm, perr, (nbits != 8), 1'b0}) begin
      errors++;
      $display("FAIL %s_hold: data=%h perr=%b lerr=%b done=%b required data=%h perr=%b lerr=%b done=0",
               name, data_out, par_err, len_err, chk_done, dm, perr, (nbits != 8));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({data_out, chk_done, par_err, len_err, sticky, err_cnt, data_out2, chk_done2, err_cnt2, sticky2} !== '0) begin
      errors++;
      $display("FAIL reset_values: data=%h done=%b perr=%b lerr=%b sticky=%b cnt=%0d, required all 0",
               data_out, chk_done, par_err, len_err, sticky, err_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_parity_modes();
    send_frame(9'h0A5, 8, 1'b0, 2'b00, 0, 0, "even_a5");
    send_frame(9'h001, 8, 1'b1, 2'b01, 0, 0, "odd_bad");
    send_frame(9'h001, 8, 1'b0, 2'b01, 0, 0, "odd_good");
    send_frame(9'h000, 8, 1'b0, 2'b10, 0, 0, "mark_bad");
    send_frame(9'h000, 8, 1'b0, 2'b11, 0, 0, "space_good");
    send_frame(9'h0C3, 8, 1'b1, 2'b00, 1, 0, "fs_with_bit");
  endtask

  task automatic test_length();
    send_frame(9'h05A, 7, 1'b0, 2'b00, 0, 0, "short7");
    send_frame(9'h1F0, 9, 1'b0, 2'b00, 0, 0, "long9");
    // Aborted frame: restart after 3 bits, must not produce a check.
    @(posedge clk); #1;
    frame_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      frame_start = 1'b0; data_bit_valid = 1'b1; sampled_bit = i[0];
    end
    @(posedge clk); #1;
    data_bit_valid = 1'b0;
    send_frame(9'h03C, 8, 1'b0, 2'b00, 0, 0, "after_abort");
  endtask

  task automatic test_counter();
    send_frame(9'h000, 8, 1'b0, 2'b11, 0, 1, "clr_only");
    for (int i = 0; i < 5; i++) send_frame(9'h001, 8, 1'b0, 2'b00, 0, 0, "bad_sat");
    checks++;
    if (err_cnt2 !== 2'd3 || err_cnt !== 8'd5) begin
      errors++;
      $display("FAIL saturate: cnt=%0d cnt2=%0d required 5 and 3", err_cnt, err_cnt2);
    end
    send_frame(9'h001, 8, 1'b0, 2'b00, 0, 1, "clr_with_err");
  endtask

  task automatic test_reset_midframe();
    @(posedge clk); #1;
    frame_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      frame_start = 1'b0; data_bit_valid = 1'b1; sampled_bit = 1'b1;
    end
    rst_n = 1'b0; data_bit_valid = 1'b0;
    #1;
    checks++;
    if ({data_out, chk_done, par_err, len_err, sticky, err_cnt, err_cnt2} !== '0) begin
      errors++;
      $display("FAIL midframe_reset: data=%h done=%b perr=%b sticky=%b cnt=%0d, required all 0",
               data_out, chk_done, par_err, sticky, err_cnt);
    end
    m_sticky = 1'b0; m_cnt = '0; m_cnt2 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (chk_done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_done: got %b required 0", chk_done);
    end
    send_frame(9'h096, 8, 1'b0, 2'b00, 0, 0, "post_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      send_frame(9'($urandom_range(0, 255)), 8, 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 0, "random");
  endtask

  initial begin
    test_reset();
    test_parity_modes();
    test_length();
    test_counter();
    test_reset_midframe();
    test_back_to_back();
    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d checks never completed, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/par_chk_serial.md
Name: par_chk_serial

Overview:
- Parametrised serial parity checker for the UART RX path, the successor of the fixed 8-bit parallel checker.
- Accumulates parity on the fly from sampled data bits (LSB first) and assembles the data word.
- Supports four parity modes and checks the parity bit when strobed.
- Maintains a per-frame error flag, a frame-length error, a sticky error and a saturating error counter for the status registers.

Parameters:
- DATA_WIDTH, 8, data bits per frame (legal 5..9).
- CNT_WIDTH, 8, width of the saturating parity-error counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- frame_start  input  1  pulse: new frame begins (start bit accepted).
- data_bit_valid  input  1  pulse: sampled_bit holds the next data bit.
- par_chk_en  input  1  pulse: sampled_bit holds the parity bit.
- sampled_bit  input  1  current sampled serial bit.
- par_mode  input  2  00 even, 01 odd, 10 mark (expect 1), 11 space (expect 0).
- err_clr  input  1  pulse: clear sticky error and counter.
- data_out  output  DATA_WIDTH  assembled data word, LSB first.
- chk_done  output  1  one-cycle pulse when a parity check completes.
- par_err  output  1  parity error of last checked frame, level.
- len_err  output  1  bit count at check was not DATA_WIDTH, level.
- par_err_sticky  output  1  set by any parity error until err_clr.
- err_cnt  output  CNT_WIDTH  parity errors since reset/err_clr, saturating.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - data_out, err_cnt: 0.
  - chk_done, par_err, len_err, par_err_sticky: 0.
  - FSM: IDLE. Internal accumulator and bit counter: 0.
- FSM states:
  - IDLE: ignores data_bit_valid and par_chk_en.
  - COLLECT: accumulates data bits.
- Input priority each cycle: frame_start > par_chk_en > data_bit_valid.
- frame_start, any state:
  - Go to COLLECT; clear accumulator, bit counter and data_out.
  - If data_bit_valid is also high that cycle, take that bit as bit 0: data_out[0] = sampled_bit, acc = sampled_bit, count = 1.
  - frame_start in COLLECT aborts the current frame; no check, no chk_done.
  - par_err and len_err keep their last values until the next check.
- data_bit_valid in COLLECT with count < DATA_WIDTH:
  - data_out[count] <= sampled_bit; acc <= acc ^ sampled_bit; count <= count + 1.
  - With count == DATA_WIDTH the bit is dropped; count saturates at DATA_WIDTH+1 to mark an overlength frame.
- par_chk_en in COLLECT, registered, 1-cycle latency:
  - expected = acc (even), ~acc (odd), 1 (mark), 0 (space).
  - par_err <= (sampled_bit != expected).
  - len_err <= (count != DATA_WIDTH).
  - chk_done pulses for one cycle; FSM returns to IDLE; data_out holds.
  - A same-cycle data_bit_valid is ignored.
- par_mode is sampled only at the par_chk_en cycle, so a mode change mid-frame takes effect at the check.
- Sticky flag and counter:
  - On a parity error: par_err_sticky <= 1; err_cnt increments, saturating at all-ones.
  - len_err alone does not touch the sticky flag or the counter.
- err_clr: par_err_sticky <= 0, err_cnt <= 0 next cycle.
  - If a parity error registers in the same cycle, that event wins after the clear: sticky = 1, err_cnt = 1.
- rst_n asserted mid-frame: everything returns to reset values at once, with no chk_done.
- Odd-mode convention is unchanged from the existing checker: error when sampled_bit == XOR of the data bits.

Test Plan:
- Even, DATA_WIDTH=8: frame_start, bits of 8'hA5 LSB first, parity 0 -> data_out=8'hA5, chk_done pulse, par_err=0, len_err=0, err_cnt=0.
- Odd: frame 8'h01 with parity 1 -> par_err=1, sticky=1, err_cnt=1. Next frame 8'h01 with parity 0 -> par_err=0, sticky stays 1, err_cnt stays 1.
- Mark/space: data 8'h00 with parity 0 in mark -> par_err=1. Same frame in space -> par_err=0.
- Length: 7 bits then par_chk_en -> len_err=1. 9 bits -> len_err=1, data_out keeps the first 8 bits. frame_start mid-frame then a full 8-bit frame -> one chk_done only, len_err=0.
- Counter: CNT_WIDTH=2, 5 bad frames -> err_cnt=3 (saturated). err_clr coincident with a 6th bad check -> err_cnt=1, sticky=1.
- Reset: assert rst_n low after 4 bits, then release and send a full good frame -> all outputs 0 during reset, no stray chk_done, next frame checks correctly.
